// File: rtl/ball_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_ctl_if
//  Description : Bundle of the frame/paddle inputs and the ball/score outputs
//                exchanged between the game-physics block and its neighbours.
//                master = drives the frame timing and paddle rows,
//                slave  = the ball controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ball_ctl_if;
   logic        frame_tick;
   logic        start;
   logic [10:0] l_pad_y;
   logic [10:0] r_pad_y;
   logic [10:0] ball_x;
   logic [10:0] ball_y;
   logic [3:0]  score_l;
   logic [3:0]  score_r;
   logic        hit_l;
   logic        hit_r;
   logic        point_l;
   logic        point_r;
   logic        in_play;
   logic        game_over;

   modport master (
      output frame_tick, start, l_pad_y, r_pad_y,
      input  ball_x, ball_y, score_l, score_r,
      input  hit_l, hit_r, point_l, point_r, in_play, game_over
   );

   modport slave (
      input  frame_tick, start, l_pad_y, r_pad_y,
      output ball_x, ball_y, score_l, score_r,
      output hit_l, hit_r, point_l, point_r, in_play, game_over
   );
endinterface
`default_nettype wire

// File: rtl/ball_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : ball_ctl
//  Description : Pong ball physics. Moves the ball once per frame, bounces it
//                off the top/bottom walls and the paddles, detects misses,
//                keeps score, holds the ball centred during the serve delay
//                and stops the game once a player reaches the winning score.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_ctl #(
   parameter int H_RES        = 1024,
   parameter int V_RES        = 768,
   parameter int BALL_SIZE    = 10,
   parameter int SPEED        = 4,
   parameter int PAD_H        = 100,
   parameter int LPAD_X_MAX   = 45,
   parameter int RPAD_X_MIN   = 979,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input wire        clk,
   input wire        rst_n,
   ball_ctl_if.slave bus
);

   // All geometry is compared in 12 bits so sums such as pad_y+PAD_H never wrap
   localparam logic [11:0] c_hres   = 12'(H_RES);
   localparam logic [11:0] c_vres   = 12'(V_RES);
   localparam logic [11:0] c_ball   = 12'(BALL_SIZE);
   localparam logic [11:0] c_speed  = 12'(SPEED);
   localparam logic [11:0] c_pad_h  = 12'(PAD_H);
   localparam logic [11:0] c_lpad   = 12'(LPAD_X_MAX);
   localparam logic [11:0] c_rpad   = 12'(RPAD_X_MIN);

   localparam logic [10:0] c_ctr_x  = 11'((H_RES - BALL_SIZE) / 2);
   localparam logic [10:0] c_ctr_y  = 11'((V_RES - BALL_SIZE) / 2);
   localparam logic [10:0] c_ybot   = 11'(V_RES - BALL_SIZE);
   localparam logic [10:0] c_rhit_x = 11'(RPAD_X_MIN - BALL_SIZE);
   localparam logic [10:0] c_lhit_x = 11'(LPAD_X_MAX + 1);

   localparam int                c_cnt_w      = $clog2(SERVE_FRAMES + 1);
   localparam logic [c_cnt_w-1:0] c_serve_last = c_cnt_w'(SERVE_FRAMES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
   localparam logic [3:0]         c_win        = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      S_SERVE = 2'd0,
      S_PLAY  = 2'd1,
      S_POINT = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t              r_state;
   logic [10:0]         r_ball_x;
   logic [10:0]         r_ball_y;
   logic                r_dir_x;        // 1 = moving right
   logic                r_dir_y;        // 1 = moving down
   logic [3:0]          r_score_l;
   logic [3:0]          r_score_r;
   logic [c_cnt_w-1:0]  r_serve_cnt;
   logic                r_left_scored;  // who scored, carried into POINT
   logic                r_hit_l;
   logic                r_hit_r;
   logic                r_point_l;
   logic                r_point_r;
   logic                r_in_play;
   logic                r_game_over;

   logic [11:0]         w_bx;
   logic [11:0]         w_by;
   logic [11:0]         w_lp;
   logic [11:0]         w_rp;
   logic [11:0]         w_nx_r;
   logic                w_l_ovl;
   logic                w_r_ovl;
   logic                w_hit_l;
   logic                w_hit_r;
   logic                w_miss_l;
   logic                w_miss_r;
   logic [10:0]         w_nbx;
   logic [10:0]         w_nby;
   logic                w_ndir_x;
   logic                w_ndir_y;
   logic [3:0]          w_score_l_inc;
   logic [3:0]          w_score_r_inc;
   logic                w_win;

   // Candidate next ball position and paddle/wall events for the current state
   always_comb begin
      w_bx   = {1'b0, r_ball_x};
      w_by   = {1'b0, r_ball_y};
      w_lp   = {1'b0, bus.l_pad_y};
      w_rp   = {1'b0, bus.r_pad_y};
      w_nx_r = w_bx + c_speed;

      // Vertical overlap uses the ball row before this frame's move
      w_l_ovl = ((w_by + c_ball) > w_lp) && (w_by <= (w_lp + c_pad_h));
      w_r_ovl = ((w_by + c_ball) > w_rp) && (w_by <= (w_rp + c_pad_h));

      // Right paddle: the move would cross its face and the ball is not already past it
      w_hit_r  = r_dir_x && ((w_nx_r + c_ball) >= c_rpad)
                 && ((w_bx + c_ball) <= c_rpad) && w_r_ovl;
      w_miss_r = r_dir_x && !w_hit_r && ((w_nx_r + c_ball) >= c_hres);
      // Left paddle: ball_x-SPEED <= LPAD_X_MAX rewritten to avoid underflow
      w_hit_l  = !r_dir_x && (w_bx <= (c_lpad + c_speed))
                 && (w_bx > c_lpad) && w_l_ovl;
      w_miss_l = !r_dir_x && !w_hit_l && (w_bx < c_speed);

      w_nbx    = r_ball_x;
      w_ndir_x = r_dir_x;
      if (w_hit_r) begin
         w_nbx    = c_rhit_x;
         w_ndir_x = 1'b0;
      end else if (w_hit_l) begin
         w_nbx    = c_lhit_x;
         w_ndir_x = 1'b1;
      end else if (r_dir_x) begin
         w_nbx    = 11'(w_nx_r);
      end else if (!w_miss_l) begin
         w_nbx    = 11'(w_bx - c_speed);
      end

      w_nby    = r_ball_y;
      w_ndir_y = r_dir_y;
      if (r_dir_y) begin
         if ((w_by + c_speed + c_ball) >= c_vres) begin
            w_nby    = c_ybot;
            w_ndir_y = 1'b0;
         end else begin
            w_nby    = 11'(w_by + c_speed);
         end
      end else begin
         if (w_by < c_speed) begin
            w_nby    = 11'd0;
            w_ndir_y = 1'b1;
         end else begin
            w_nby    = 11'(w_by - c_speed);
         end
      end

      w_score_l_inc = r_score_l + 4'd1;
      w_score_r_inc = r_score_r + 4'd1;
      w_win = r_left_scored ? (w_score_l_inc == c_win) : (w_score_r_inc == c_win);
   end

   // Game state machine; every output is registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_SERVE;
         r_ball_x      <= c_ctr_x;
         r_ball_y      <= c_ctr_y;
         r_dir_x       <= 1'b1;
         r_dir_y       <= 1'b1;
         r_score_l     <= 4'd0;
         r_score_r     <= 4'd0;
         r_serve_cnt   <= '0;
         r_left_scored <= 1'b0;
         r_hit_l       <= 1'b0;
         r_hit_r       <= 1'b0;
         r_point_l     <= 1'b0;
         r_point_r     <= 1'b0;
         r_in_play     <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         r_hit_l   <= 1'b0;
         r_hit_r   <= 1'b0;
         r_point_l <= 1'b0;
         r_point_r <= 1'b0;

         case (r_state)
            S_SERVE: begin
               r_ball_x <= c_ctr_x;
               r_ball_y <= c_ctr_y;
               if (bus.frame_tick) begin
                  if (r_serve_cnt == c_serve_last) begin
                     r_serve_cnt <= '0;
                     r_state     <= S_PLAY;
                     r_in_play   <= 1'b1;
                  end else begin
                     r_serve_cnt <= r_serve_cnt + c_cnt_one;
                  end
               end
            end

            S_PLAY: begin
               if (bus.frame_tick) begin
                  // Wall bounce applies even on the frame the ball is missed
                  r_ball_y <= w_nby;
                  r_dir_y  <= w_ndir_y;
                  if (w_miss_r || w_miss_l) begin
                     r_left_scored <= w_miss_r;
                     r_state       <= S_POINT;
                     r_in_play     <= 1'b0;
                  end else begin
                     r_ball_x <= w_nbx;
                     r_dir_x  <= w_ndir_x;
                     r_hit_l  <= w_hit_l;
                     r_hit_r  <= w_hit_r;
                  end
               end
            end

            S_POINT: begin
               r_ball_x    <= c_ctr_x;
               r_ball_y    <= c_ctr_y;
               // Next serve heads toward the player who just lost the point
               r_dir_x     <= r_left_scored;
               r_serve_cnt <= '0;
               if (r_left_scored) begin
                  r_score_l <= w_score_l_inc;
                  r_point_l <= 1'b1;
               end else begin
                  r_score_r <= w_score_r_inc;
                  r_point_r <= 1'b1;
               end
               if (w_win) begin
                  r_state     <= S_OVER;
                  r_game_over <= 1'b1;
               end else begin
                  r_state     <= S_SERVE;
               end
            end

            S_OVER: begin
               r_ball_x <= c_ctr_x;
               r_ball_y <= c_ctr_y;
               if (bus.start) begin
                  r_score_l   <= 4'd0;
                  r_score_r   <= 4'd0;
                  r_serve_cnt <= '0;
                  r_state     <= S_SERVE;
                  r_game_over <= 1'b0;
               end
            end

            default: begin
               r_state <= S_SERVE;
            end
         endcase
      end
   end

   assign bus.ball_x    = r_ball_x;
   assign bus.ball_y    = r_ball_y;
   assign bus.score_l   = r_score_l;
   assign bus.score_r   = r_score_r;
   assign bus.hit_l     = r_hit_l;
   assign bus.hit_r     = r_hit_r;
   assign bus.point_l   = r_point_l;
   assign bus.point_r   = r_point_r;
   assign bus.in_play   = r_in_play;
   assign bus.game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_ball_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_ctl
//  Description : Self-checking bench for ball_ctl. A behavioural game model
//                predicts every frame; predictions are queued and compared
//                against the DUT a few cycles after each tick. A table of
//                hand-derived waypoints checks the long rally, and directed
//                sequences cover game-over, start and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_ctl;

   logic clk = 1'b0;
   logic rst_n;

   ball_ctl_if bus ();

   ball_ctl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x; int y; int sl; int sr; int ip; int go;
      int hl; int hr; int pl; int pr;
   } exp_t;

   typedef struct {
      int ticks; int lpy; int rpy;
      int x; int y; int sl; int sr; int ip; int go;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference game model (0 serve, 1 play, 2 over; dirs 1 = right/down)
   int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_st;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_x = 507; m_y = 379; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_cnt = 0; m_st = 0;
   endtask

   task automatic model_tick(input int lpy, input int rpy,
                             output int hl, output int hr, output int pl, output int pr);
      int ny;
      int scorer;
      hl = 0; hr = 0; pl = 0; pr = 0; scorer = 0; ny = m_y;
      case (m_st)
         0: begin
            m_cnt++;
            if (m_cnt == 60) begin m_cnt = 0; m_st = 1; end
         end
         1: begin
            if (m_dy == 1) begin
               if (m_y + 14 >= 768) begin ny = 758; m_dy = 0; end
               else ny = m_y + 4;
            end else begin
               if (m_y < 4) begin ny = 0; m_dy = 1; end
               else ny = m_y - 4;
            end
            if (m_dx == 1) begin
               if (m_x + 14 >= 979 && m_x + 10 <= 979 && m_y + 10 > rpy && m_y <= rpy + 100) begin
                  m_x = 969; m_dx = 0; hr = 1;
               end else if (m_x + 14 >= 1024) scorer = 1;
               else m_x = m_x + 4;
            end else begin
               if (m_x - 4 <= 45 && m_x > 45 && m_y + 10 > lpy && m_y <= lpy + 100) begin
                  m_x = 46; m_dx = 1; hl = 1;
               end else if (m_x < 4) scorer = 2;
               else m_x = m_x - 4;
            end
            m_y = ny;
            if (scorer != 0) begin
               m_x = 507; m_y = 379; m_cnt = 0;
               if (scorer == 1) begin m_sl++; pl = 1; m_dx = 1; end
               else begin m_sr++; pr = 1; m_dx = 0; end
               m_st = (m_sl == 9 || m_sr == 9) ? 2 : 0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic push_expect(input int hl, input int hr, input int pl, input int pr);
      exp_t e;
      e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr;
      e.ip = (m_st == 1) ? 1 : 0; e.go = (m_st == 2) ? 1 : 0;
      e.hl = hl; e.hr = hr; e.pl = pl; e.pr = pr;
      sb.push_back(e);
   endtask

   task automatic sb_compare(input int hl, input int hr, input int pl, input int pr);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb.pop_front();
      check("ball_x",    int'(bus.ball_x),    e.x);
      check("ball_y",    int'(bus.ball_y),    e.y);
      check("score_l",   int'(bus.score_l),   e.sl);
      check("score_r",   int'(bus.score_r),   e.sr);
      check("in_play",   int'(bus.in_play),   e.ip);
      check("game_over", int'(bus.game_over), e.go);
      check("hit_l_cycles",   hl, e.hl);
      check("hit_r_cycles",   hr, e.hr);
      check("point_l_cycles", pl, e.pl);
      check("point_r_cycles", pr, e.pr);
   endtask

   // Sample pulses for four cycles after a stimulus, leaving outputs settled
   task automatic pulse_window(output int hl, output int hr, output int pl, output int pr);
      hl = 0; hr = 0; pl = 0; pr = 0;
      repeat (4) begin
         hl += int'(bus.hit_l);   hr += int'(bus.hit_r);
         pl += int'(bus.point_l); pr += int'(bus.point_r);
         @(negedge clk);
      end
   endtask

   task automatic do_tick(input int lpy, input int rpy);
      int ehl, ehr, epl, epr, hl, hr, pl, pr;
      bus.l_pad_y = 11'(lpy);
      bus.r_pad_y = 11'(rpy);
      model_tick(lpy, rpy, ehl, ehr, epl, epr);
      push_expect(ehl, ehr, epl, epr);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      pulse_window(hl, hr, pl, pr);
      sb_compare(hl, hr, pl, pr);
   endtask

   task automatic do_start();
      int hl, hr, pl, pr;
      if (m_st == 2) begin m_sl = 0; m_sr = 0; m_cnt = 0; m_st = 0; end
      push_expect(0, 0, 0, 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      pulse_window(hl, hr, pl, pr);
      sb_compare(hl, hr, pl, pr);
   endtask

   initial begin
      // Hand-derived waypoints of the first rally: ticks run, pads, then expected state
      vecs[0]  = '{59,  200, 600,  507, 379, 0, 0, 0, 0};
      vecs[1]  = '{1,   200, 600,  507, 379, 0, 0, 1, 0};
      vecs[2]  = '{1,   200, 600,  511, 383, 0, 0, 1, 0};
      vecs[3]  = '{93,  200, 600,  883, 755, 0, 0, 1, 0};
      vecs[4]  = '{1,   200, 600,  887, 758, 0, 0, 1, 0};
      vecs[5]  = '{1,   200, 600,  891, 754, 0, 0, 1, 0};
      vecs[6]  = '{19,  200, 600,  967, 678, 0, 0, 1, 0};
      vecs[7]  = '{1,   200, 600,  969, 674, 0, 0, 1, 0};
      vecs[8]  = '{1,   200, 600,  965, 670, 0, 0, 1, 0};
      vecs[9]  = '{229, 200, 600,   49, 244, 0, 0, 1, 0};
      vecs[10] = '{1,   200, 600,   46, 248, 0, 0, 1, 0};
      vecs[11] = '{241, 200, 0,   1010, 306, 0, 0, 1, 0};
      vecs[12] = '{1,   200, 0,    507, 379, 1, 0, 0, 0};

      rst_n          = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      bus.l_pad_y    = 11'd0;
      bus.r_pad_y    = 11'd0;
      model_reset();
      repeat (3) @(negedge clk);

      check("rst_ball_x",    int'(bus.ball_x),    507);
      check("rst_ball_y",    int'(bus.ball_y),    379);
      check("rst_score_l",   int'(bus.score_l),   0);
      check("rst_score_r",   int'(bus.score_r),   0);
      check("rst_in_play",   int'(bus.in_play),   0);
      check("rst_game_over", int'(bus.game_over), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Serve delay, wall bounce, right hit, left hit and a miss
      foreach (vecs[i]) begin
         for (int t = 0; t < vecs[i].ticks; t++) do_tick(vecs[i].lpy, vecs[i].rpy);
         check($sformatf("vec%0d_ball_x", i),  int'(bus.ball_x),  vecs[i].x);
         check($sformatf("vec%0d_ball_y", i),  int'(bus.ball_y),  vecs[i].y);
         check($sformatf("vec%0d_score_l", i), int'(bus.score_l), vecs[i].sl);
         check($sformatf("vec%0d_score_r", i), int'(bus.score_r), vecs[i].sr);
         check($sformatf("vec%0d_in_play", i), int'(bus.in_play), vecs[i].ip);
         check($sformatf("vec%0d_over", i),    int'(bus.game_over), vecs[i].go);
      end

      // Right paddle out of reach: left keeps scoring until the game ends
      for (int t = 0; t < 3000 && m_st != 2; t++) do_tick(0, 2047);
      check("final_score_l", int'(bus.score_l),   9);
      check("final_over",    int'(bus.game_over), 1);

      // Ticks are ignored while the game is over
      repeat (5) do_tick(0, 2047);
      do_start();
      check("restart_score_l", int'(bus.score_l), 0);
      check("restart_over",    int'(bus.game_over), 0);

      // Start is ignored outside OVER
      repeat (10) do_tick(0, 2047);
      do_start();
      repeat (50) do_tick(0, 2047);
      check("replay_in_play", int'(bus.in_play), 1);
      repeat (5) do_tick(0, 2047);

      // Async reset between clock edges takes effect immediately
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ball_x",    int'(bus.ball_x),    507);
      check("arst_ball_y",    int'(bus.ball_y),    379);
      check("arst_score_l",   int'(bus.score_l),   0);
      check("arst_in_play",   int'(bus.in_play),   0);
      check("arst_game_over", int'(bus.game_over), 0);
      check("arst_hit_r",     int'(bus.hit_r),     0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      repeat (60) do_tick(0, 2047);
      do_tick(0, 2047);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
